// File: rtl/dram_multi_clr_pkg.sv
// Shared constants for the multi-port distributed RAM with clear sweep.
package dram_multi_clr_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

// File: rtl/dram_multi_clr.sv
// Lane-writable distributed RAM with NUM_RD read ports and a self-timed clear sweep.
module dram_multi_clr
  import dram_multi_clr_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 6,
  parameter int unsigned LANE_BITS = 8,
  parameter int unsigned LANES     = 1,
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned REG_OUT   = 0,
  parameter logic [LANES*LANE_BITS-1:0] CLR_VAL = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic [LANES-1:0]                   we,
  input  logic [ADDR_BITS-1:0]               addrd,
  input  logic [LANES*LANE_BITS-1:0]         did,
  input  logic [NUM_RD*ADDR_BITS-1:0]        addra,
  output logic [NUM_RD*LANES*LANE_BITS-1:0]  doa,
  input  logic                               clr,
  output logic                               busy
);

  localparam int unsigned DEPTH     = 1 << ADDR_BITS;
  localparam int unsigned DATA_BITS = LANES * LANE_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  logic [0:0]                    state_q, state_d;
  logic [ADDR_BITS-1:0]          cnt_q, cnt_d;
  logic [LANES-1:0]              wr_en_c;
  logic [ADDR_BITS-1:0]          wr_addr_c;
  logic [DATA_BITS-1:0]          wr_data_c;
  logic [NUM_RD*DATA_BITS-1:0]   rd_c;

  // Next state and write-port arbitration: the sweep owns the write port while busy.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_c   = '0;
    wr_addr_c = addrd;
    wr_data_c = did;
    if (state_q == ST_IDLE) begin
      if (en) begin
        wr_en_c = we;
      end
      if (clr) begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    end else begin
      wr_en_c   = '1;
      wr_addr_c = cnt_q;
      wr_data_c = CLR_VAL;
      cnt_d     = cnt_q + ADDR_BITS'(1);
      if (cnt_q == LAST_ADDR) begin
        state_d = ST_IDLE;
      end
    end
    if (rst) begin
      wr_en_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == ST_CLEAR);

  // One storage array per lane; contents are deliberately not reset.
  for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
    logic [LANE_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_en_c[k]) begin
        mem[wr_addr_c] <= wr_data_c[k*LANE_BITS +: LANE_BITS];
      end
    end

    for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
      assign rd_c[p*DATA_BITS + k*LANE_BITS +: LANE_BITS] = mem[addra[p*ADDR_BITS +: ADDR_BITS]];
    end
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [NUM_RD*DATA_BITS-1:0] doa_d, doa_q;

    always_comb doa_d = rd_c;

    // Sampled before the same-edge write lands, giving read-first behaviour.
    always_ff @(posedge clk) begin
      if (rst) begin
        doa_q <= '0;
      end else begin
        doa_q <= doa_d;
      end
    end

    assign doa = doa_q;
  end else begin : g_comb_out
    assign doa = rd_c;
  end

endmodule

// File: tb/tb_dram_multi_clr.sv
// Scoreboard bench: one asynchronous-read and one registered-read instance on shared stimulus.
module tb_dram_multi_clr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [1:0]  we  = '0;
  logic [3:0]  addrd = '0;
  logic [15:0] did = '0;
  logic [7:0]  addra = '0;
  logic        clr = 1'b0;
  logic [31:0] doa_c, doa_r;
  logic        busy_c, busy_r;

  int cyc   = 0;
  int tag   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    int          cyc;
    int          kind;   // 0 async doa, 1 registered doa, 2 async busy, 3 registered busy
    int          port;
    int          tag;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];

  dram_multi_clr #(
    .ADDR_BITS(4), .LANE_BITS(8), .LANES(2), .NUM_RD(2), .REG_OUT(0), .CLR_VAL(16'hFFFF)
  ) u_dut_c (
    .clk(clk), .rst(rst), .en(en), .we(we), .addrd(addrd), .did(did),
    .addra(addra), .doa(doa_c), .clr(clr), .busy(busy_c)
  );

  dram_multi_clr #(
    .ADDR_BITS(4), .LANE_BITS(8), .LANES(2), .NUM_RD(2), .REG_OUT(1), .CLR_VAL(16'hFFFF)
  ) u_dut_r (
    .clk(clk), .rst(rst), .en(en), .we(we), .addrd(addrd), .did(did),
    .addra(addra), .doa(doa_r), .clr(clr), .busy(busy_r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kind_name(input int k);
    case (k)
      0:       return "rd_async";
      1:       return "rd_reg";
      2:       return "busy_async";
      default: return "busy_reg";
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    int i;
    exp_t e;
    logic [15:0] got;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc <= cyc) begin
        e = sb[i];
        sb.delete(i);
        case (e.kind)
          0:       got = doa_c[e.port*16 +: 16];
          1:       got = doa_r[e.port*16 +: 16];
          2:       got = {15'd0, busy_c};
          default: got = {15'd0, busy_r};
        endcase
        n_cmp++;
        if (got !== e.exp || e.cyc != cyc) begin
          n_bad++;
          $display("FAIL %s tag=%0d port=%0d cyc=%0d due=%0d got=%h exp=%h",
                   kind_name(e.kind), e.tag, e.port, cyc, e.cyc, got, e.exp);
        end
      end else begin
        i++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input int kind, input int port, input logic [15:0] exp);
    exp_t e;
    e.cyc = c; e.kind = kind; e.port = port; e.tag = tag; e.exp = exp;
    sb.push_back(e);
  endtask

  // Async port shows data this cycle; registered port one cycle later.
  task automatic expect_rd(input int port, input logic [15:0] exp);
    push(cyc, 0, port, exp);
    push(cyc + 1, 1, port, exp);
  endtask

  task automatic expect_busy(input logic b);
    push(cyc, 2, 0, {15'd0, b});
    push(cyc, 3, 0, {15'd0, b});
  endtask

  task automatic set_rd(input logic [3:0] a0, input logic [3:0] a1);
    addra = {a1, a0};
  endtask

  task automatic write(input logic [3:0] a, input logic [1:0] w, input logic [15:0] d);
    en = 1'b1; we = w; addrd = a; did = d;
    tick();
    en = 1'b0; we = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [15:0] v0, v1;

    // Reset state
    tag = 13;
    tick();
    tick();
    expect_busy(1'b0);
    push(cyc, 1, 0, 16'h0000);
    push(cyc, 1, 1, 16'h0000);
    rst = 1'b0;
    tick();

    // Full write, both ports same address
    tag = 17;
    write(4'd3, 2'b11, 16'hA55A);
    set_rd(4'd3, 4'd3);
    expect_rd(0, 16'hA55A);
    expect_rd(1, 16'hA55A);
    tick();

    // Lane-masked write
    tag = 18;
    write(4'd5, 2'b11, 16'h1234);
    write(4'd5, 2'b10, 16'hAB00);
    set_rd(4'd3, 4'd5);
    expect_rd(0, 16'hA55A);
    expect_rd(1, 16'hAB34);
    tick();

    // en=0 blocks writes
    tag = 12;
    en = 1'b0; we = 2'b11; addrd = 4'd3; did = 16'h0000;
    tick();
    we = '0;
    set_rd(4'd3, 4'd5);
    expect_rd(0, 16'hA55A);
    expect_rd(1, 16'hAB34);
    tick();

    // Sweep started together with a user write to addr 9
    tag = 19;
    clr = 1'b1; en = 1'b1; we = 2'b11; addrd = 4'd9; did = 16'h5A5A;
    tick();
    clr = 1'b0; en = 1'b0; we = '0;
    for (int i = 1; i <= 16; i++) begin
      expect_busy(1'b1);
      if (i == 1) begin
        tag = 10;
        set_rd(4'd9, 4'd5);
        expect_rd(0, 16'h5A5A);
        expect_rd(1, 16'hAB34);
      end
      if (i == 2) begin
        tag = 9;
        set_rd(4'd0, 4'd5);
        expect_rd(0, 16'hFFFF);
        expect_rd(1, 16'hAB34);
      end
      if (i == 3) begin
        tag = 20;
        en = 1'b1; we = 2'b11; addrd = 4'd15; did = 16'h0001;
      end
      if (i == 4) begin
        tag = 19;
        en = 1'b0; we = '0; clr = 1'b1;
      end
      if (i == 5) begin
        clr = 1'b0;
        en = 1'b1; we = 2'b11; addrd = 4'd0; did = 16'h0001;
      end
      if (i == 6) begin
        en = 1'b0; we = '0;
      end
      tick();
    end
    expect_busy(1'b0);
    for (int a = 0; a < 16; a++) begin
      set_rd(4'(a), 4'(15 - a));
      expect_rd(0, 16'hFFFF);
      expect_rd(1, 16'hFFFF);
      tick();
    end

    // Pre-fill, then reset during sweep cycle 8
    tag = 21;
    for (int a = 0; a < 16; a++) write(4'(a), 2'b11, 16'h1000 + 16'(a));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      expect_busy(1'b1);
      if (i == 9) rst = 1'b1;
      tick();
    end
    expect_busy(1'b0);
    push(cyc, 1, 0, 16'h0000);
    push(cyc, 1, 1, 16'h0000);
    rst = 1'b0;
    tick();
    expect_busy(1'b0);
    for (int a = 0; a < 16; a++) begin
      v0 = (a < 8) ? 16'hFFFF : 16'h1000 + 16'(a);
      v1 = ((15 - a) < 8) ? 16'hFFFF : 16'h1000 + 16'(15 - a);
      set_rd(4'(a), 4'(15 - a));
      expect_rd(0, v0);
      expect_rd(1, v1);
      tick();
    end

    // Same-edge read and write: registered port is read-first
    tag = 22;
    set_rd(4'd2, 4'd8);
    en = 1'b1; we = 2'b11; addrd = 4'd2; did = 16'h00C3;
    expect_rd(0, 16'hFFFF);
    expect_rd(1, 16'h1008);
    tick();
    en = 1'b0; we = '0;
    expect_rd(0, 16'h00C3);
    tick();
    tick();
    tick();

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
